// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 scan constants, RGB565 palette and bar lookup
package vga_pkg;

  localparam int H_ACT_START = 143;
  localparam int V_ACT_START = 35;
  localparam int H_ACT       = 640;
  localparam int V_ACT       = 480;
  localparam int H_LAST      = 799;
  localparam int V_LAST      = 524;
  localparam int BOX_SIZE    = 32;
  localparam int STEP        = 2;

  function automatic logic [15:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hF800;
      3'd1:    return 16'hFC00;
      3'd2:    return 16'hFFE0;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'h07FF;
      3'd5:    return 16'h001F;
      3'd6:    return 16'hF81F;
      default: return 16'hFFFF;
    endcase
  endfunction

  // col/80 for col in 0..639, built from comparators rather than a divider
  function automatic logic [2:0] bar_idx(input logic [9:0] col);
    if (col < 10'd80)       return 3'd0;
    else if (col < 10'd160) return 3'd1;
    else if (col < 10'd240) return 3'd2;
    else if (col < 10'd320) return 3'd3;
    else if (col < 10'd400) return 3'd4;
    else if (col < 10'd480) return 3'd5;
    else if (col < 10'd560) return 3'd6;
    else                    return 3'd7;
  endfunction

endpackage

// File: rtl/box_axis_mover.sv
// rtl/box_axis_mover.sv - one axis of the bouncing square: position, direction, wall hit
module box_axis_mover #(
  parameter int MAX  = 608,
  parameter int STEP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  output logic [9:0] pos,
  output logic       hit
);

  localparam logic [10:0] MAX11  = 11'(MAX);
  localparam logic [10:0] STEP11 = 11'(STEP);

  logic [9:0]  pos_q, pos_d;
  logic        dir_neg_q, dir_neg_d;
  logic [10:0] pos_inc;

  // 11-bit sum so the wall compare never sees a wrapped value
  assign pos_inc = {1'b0, pos_q} + STEP11;

  always_comb begin
    pos_d     = pos_q;
    dir_neg_d = dir_neg_q;
    hit       = 1'b0;
    if (tick_en) begin
      if (!dir_neg_q) begin
        if (pos_inc >= MAX11) begin
          pos_d     = MAX11[9:0];
          dir_neg_d = 1'b1;
          hit       = 1'b1;
        end else begin
          pos_d = pos_inc[9:0];
        end
      end else begin
        if ({1'b0, pos_q} <= STEP11) begin
          pos_d     = 10'd0;
          dir_neg_d = 1'b0;
          hit       = 1'b1;
        end else begin
          pos_d = pos_q - STEP11[9:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= 10'd0;
      dir_neg_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      dir_neg_q <= dir_neg_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/vga_bounce_pic.sv
// rtl/vga_bounce_pic.sv - colour bars with a bouncing square, registered RGB565 out
module vga_bounce_pic
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        move_en,
  output logic [15:0] pix_data,
  output logic [7:0]  bounce_cnt
);

  localparam logic [9:0]  H0     = 10'(H_ACT_START);
  localparam logic [9:0]  V0     = 10'(V_ACT_START);
  localparam logic [9:0]  H_END  = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0]  V_END  = 10'(V_ACT_START + V_ACT);
  localparam logic [10:0] BOX11  = 11'(BOX_SIZE);

  logic [9:0]  col, row, box_x, box_y;
  logic        active, in_box, frame_tick, tick_en, hit_x, hit_y;
  logic [2:0]  box_idx_q, box_idx_d;
  logic [7:0]  bounce_q, bounce_d;
  logic [15:0] pix_q, pix_d;

  assign frame_tick = (pix_x == 10'(H_LAST)) && (pix_y == 10'(V_LAST));
  assign tick_en    = frame_tick && move_en;

  box_axis_mover #(.MAX(H_ACT - BOX_SIZE), .STEP(STEP)) u_mover_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en),
    .pos     (box_x),
    .hit     (hit_x)
  );

  box_axis_mover #(.MAX(V_ACT - BOX_SIZE), .STEP(STEP)) u_mover_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en),
    .pos     (box_y),
    .hit     (hit_y)
  );

  // col/row wrap for blanking coordinates; active gates them off
  assign col    = pix_x - H0;
  assign row    = pix_y - V0;
  assign active = (pix_x >= H0) && (pix_x < H_END) && (pix_y >= V0) && (pix_y < V_END);
  assign in_box = (col >= box_x) && ({1'b0, col} < ({1'b0, box_x} + BOX11)) &&
                  (row >= box_y) && ({1'b0, row} < ({1'b0, box_y} + BOX11));

  always_comb begin
    box_idx_d = box_idx_q;
    bounce_d  = bounce_q;
    // a corner hit is a single event
    if (tick_en && (hit_x || hit_y)) begin
      box_idx_d = box_idx_q + 3'd1;
      bounce_d  = bounce_q + 8'd1;
    end
    pix_d = 16'h0000;
    if (active) begin
      pix_d = in_box ? palette(box_idx_q) : palette(bar_idx(col));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_idx_q <= 3'd7;
      bounce_q  <= 8'd0;
      pix_q     <= 16'h0000;
    end else begin
      box_idx_q <= box_idx_d;
      bounce_q  <= bounce_d;
      pix_q     <= pix_d;
    end
  end

  assign pix_data   = pix_q;
  assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_vga_bounce_pic.sv
// tb/tb_vga_bounce_pic.sv - directed bench for vga_bounce_pic
module tb_vga_bounce_pic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x, pix_y;
  logic        move_en;
  logic [15:0] pix_data;
  logic [7:0]  bounce_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  vga_bounce_pic dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .move_en    (move_en),
    .pix_data   (pix_data),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic probe(input int x, input int y, input logic [15:0] exp, input string tag);
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk);
    #1;
    chk16(tag, pix_data, exp);
  endtask

  task automatic ticks(input int n);
    @(negedge clk);
    pix_x = 10'd799;
    pix_y = 10'd524;
    repeat (n) @(posedge clk);
    @(negedge clk);
    pix_x = 10'd0;
    pix_y = 10'd0;
  endtask

  initial begin
    rst_n   = 1'b0;
    pix_x   = 10'd0;
    pix_y   = 10'd0;
    move_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk16("reset_pix", pix_data, 16'h0000);
    chk8("reset_bounce", bounce_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    probe(143, 35, 16'hFFFF, "box_origin");
    probe(174, 35, 16'hFFFF, "box_right_edge");
    probe(175, 35, 16'hF800, "past_box_bar0");
    probe(143, 66, 16'hFFFF, "box_bottom_edge");
    probe(143, 67, 16'hF800, "below_box_bar0");
    probe(223, 135, 16'hFC00, "bar1_start");
    probe(782, 100, 16'hFFFF, "last_col_bar7");
    probe(783, 100, 16'h0000, "col640_blank");
    probe(100, 100, 16'h0000, "hblank");
    probe(300, 20, 16'h0000, "vblank");
    probe(300, 515, 16'h0000, "row480_blank");

    move_en = 1'b1;
    ticks(1);
    probe(143, 35, 16'hF800, "t1_origin_bar0");
    probe(144, 37, 16'hF800, "t1_left_of_box");
    probe(145, 37, 16'hFFFF, "t1_box_at_2_2");
    chk8("t1_bounce", bounce_cnt, 8'd0);

    ticks(223);
    chk8("t224_bounce", bounce_cnt, 8'd1);
    probe(591, 483, 16'hF800, "t224_box_448_448");
    probe(622, 514, 16'hF800, "t224_box_far_corner");
    probe(590, 483, 16'h001F, "t224_left_bar5");
    probe(591, 482, 16'h001F, "t224_above_bar5");

    ticks(1);
    probe(593, 481, 16'hF800, "t225_box_450_446");
    probe(592, 481, 16'h001F, "t225_left_bar5");
    probe(593, 480, 16'h001F, "t225_above_bar5");
    chk8("t225_bounce", bounce_cnt, 8'd1);

    ticks(4256 - 225);
    chk8("corner_bounce", bounce_cnt, 8'd32);
    probe(143, 483, 16'hFFFF, "corner_box_0_448");
    probe(143, 482, 16'hF800, "corner_above");
    probe(175, 483, 16'hF800, "corner_right");
    probe(174, 514, 16'hFFFF, "corner_box_far");

    move_en = 1'b0;
    ticks(10);
    chk8("frozen_bounce", bounce_cnt, 8'd32);
    probe(143, 483, 16'hFFFF, "frozen_box");
    probe(143, 482, 16'hF800, "frozen_above");

    move_en = 1'b1;
    ticks(1);
    probe(145, 481, 16'hFFFF, "resume_box_2_446");
    probe(144, 481, 16'hF800, "resume_left");
    probe(145, 480, 16'hF800, "resume_above");
    chk8("resume_bounce", bounce_cnt, 8'd32);

    ticks(5);
    probe(155, 471, 16'hFFFF, "pre_reset_box_12_436");
    #3;
    rst_n = 1'b0;
    #1;
    chk16("async_reset_pix", pix_data, 16'h0000);
    chk8("async_reset_bounce", bounce_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    probe(143, 35, 16'hFFFF, "rr_box_origin");
    probe(175, 35, 16'hF800, "rr_bar0");
    probe(223, 135, 16'hFC00, "rr_bar1");
    probe(100, 35, 16'h0000, "rr_hblank");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
